idma_stream_stall_injector: RTL and testbench

//  Single-entry valid/ready stream stage that inserts pseudo-random stall cycles

---
 rtl/idma_stream_stall_injector.sv | 143 ++++++++++++++
 tb/tb_idma_stream_stall_injector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_stream_stall_injector.sv
// rtl/idma_stream_stall_injector.sv - single-entry stream stage with LFSR-driven stall insertion
// Optional IDMA_STALL_STATS_EN adds saturating beat and stall-cycle counters.
module idma_stream_stall_injector #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned StallWidth = 8,
    parameter logic [31:0] LfsrSeed   = 32'h0000_0005
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic [StallWidth-1:0] cfg_max_stall_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DataWidth-1:0]  in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DataWidth-1:0]  out_data_o,
`ifdef IDMA_STALL_STATS_EN
    input  logic                  stat_clr_i,
    output logic [31:0]           stat_beats_o,
    output logic [31:0]           stat_stall_cycles_o,
`endif
    output logic                  stalling_o
);

    localparam logic [31:0] LfsrTaps = 32'h8020_0003;

    if (LfsrSeed == 32'd0) begin : g_seed_check
        $fatal(1, "idma_stream_stall_injector: LfsrSeed must be nonzero");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        STALL = 2'd1,
        VALID = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DataWidth-1:0]  data_q, data_d;
    logic [StallWidth-1:0] cnt_q, cnt_d;
    logic [31:0]           lfsr_q, lfsr_d;

    logic                  in_ready;
    logic                  accept;
    logic                  out_hs;
    logic [31:0]           lfsr_next;
    logic [StallWidth-1:0] new_cnt;

    assign in_ready  = (state_q == EMPTY) || ((state_q == VALID) && out_ready_i);
    assign accept    = in_valid_i && in_ready;
    assign out_hs    = (state_q == VALID) && out_ready_i;
    assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'd0);
    // Stall length uses the LFSR value before this beat advances it.
    assign new_cnt   = cfg_en_i ? (lfsr_q[StallWidth-1:0] & cfg_max_stall_i) : '0;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        if (accept) begin
            data_d  = in_data_i;
            lfsr_d  = lfsr_next;
            cnt_d   = new_cnt;
            state_d = (new_cnt == '0) ? VALID : STALL;
        end else begin
            case (state_q)
                EMPTY: state_d = EMPTY;
                STALL: begin
                    if (cnt_q == StallWidth'(1)) begin
                        state_d = VALID;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - StallWidth'(1);
                    end
                end
                VALID: begin
                    if (out_ready_i) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
            lfsr_q  <= LfsrSeed;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = (state_q == VALID);
    assign out_data_o  = data_q;
    assign stalling_o  = (state_q == STALL);

`ifdef IDMA_STALL_STATS_EN
    logic [31:0] beats_q, beats_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;

    always_comb begin
        beats_d     = beats_q;
        stall_cyc_d = stall_cyc_q;
        if (stat_clr_i) begin
            beats_d     = '0;
            stall_cyc_d = '0;
        end else begin
            if (out_hs && (beats_q != 32'hFFFF_FFFF)) begin
                beats_d = beats_q + 32'd1;
            end
            if ((state_q == STALL) && (stall_cyc_q != 32'hFFFF_FFFF)) begin
                stall_cyc_d = stall_cyc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beats_q     <= '0;
            stall_cyc_q <= '0;
        end else begin
            beats_q     <= beats_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign stat_beats_o        = beats_q;
    assign stat_stall_cycles_o = stall_cyc_q;
`else
    logic unused_hs;
    assign unused_hs = out_hs;
`endif

endmodule

// File: tb/tb_idma_stream_stall_injector.sv
// tb/tb_idma_stream_stall_injector.sv - self-checking bench for idma_stream_stall_injector
module tb_idma_stream_stall_injector;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic [7:0]  cfg_mask;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        stalling;
`ifdef IDMA_STALL_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_beats;
    logic [31:0] stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    idma_stream_stall_injector #(
        .DataWidth (32),
        .StallWidth(8),
        .LfsrSeed  (32'h0000_0005)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cfg_en_i           (cfg_en),
        .cfg_max_stall_i    (cfg_mask),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_data_i          (in_data),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_data_o         (out_data),
`ifdef IDMA_STALL_STATS_EN
        .stat_clr_i         (stat_clr),
        .stat_beats_o       (stat_beats),
        .stat_stall_cycles_o(stat_stall),
`endif
        .stalling_o         (stalling)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [7:0]  mask;
        logic [31:0] data;
        int          exp_stall;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        // Galois form: shift right, fold the polynomial in when a one drops out.
        if (x % 2 == 1) return (x / 2) ^ 32'h8020_0003;
        return x / 2;
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef IDMA_STALL_STATS_EN
        stat_clr  = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_stalling", {31'd0, stalling}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Starts and ends on a negedge; leaves the beat presented with out_ready=1.
    task automatic send_one(input logic en, input logic [7:0] mask, input logic [31:0] data,
                            output int stall, output int lat);
        int w;
        cfg_en    = en;
        cfg_mask  = mask;
        in_valid  = 1'b1;
        in_data   = data;
        out_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 50) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        stall = 0;
        lat   = 1;
        while (!out_valid && lat < 100) begin
            if (stalling) stall++;
            @(negedge clk);
            lat++;
        end
        check("send_data", out_data, data);
    endtask

    logic [31:0] m_lfsr;
    logic [31:0] prev_data;
    logic [31:0] exp_q[$];
    logic        prev_ov, prev_or, acc, hs, new_beat;
    int          stall, lat, run, cur_cnt, sent, cyc, stab_err, long_err, bad_ov;
    int          streak_o, streak_i, max_streak;

    initial begin
        vecs[0] = '{en: 1'b1, mask: 8'hFF, data: 32'hA5A5_A5A5, exp_stall: 5};
        vecs[1] = '{en: 1'b1, mask: 8'h0F, data: 32'h1234_5678, exp_stall: 1};
        vecs[2] = '{en: 1'b0, mask: 8'hFF, data: 32'hDEAD_BEEF, exp_stall: 0};
        vecs[3] = '{en: 1'b1, mask: 8'hFF, data: 32'h0000_0001, exp_stall: 2};
        vecs[4] = '{en: 1'b1, mask: 8'h0E, data: 32'hFFFF_FFFF, exp_stall: 0};

        cfg_en = 1'b0; cfg_mask = 8'h00; in_data = 32'd0;
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
`ifdef IDMA_STALL_STATS_EN
        stat_clr = 1'b0;
`endif
        do_reset();

        // Table: consecutive beats from reset walk the LFSR sequence from the seed.
        for (int i = 0; i < 5; i++) begin
            send_one(vecs[i].en, vecs[i].mask, vecs[i].data, stall, lat);
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_stall + 1);
        end
        @(negedge clk);
        check("vec_drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back beats with stalls disabled.
        do_reset();
        cfg_en = 1'b0; cfg_mask = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            #1;
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
            check("b2b_out_data", out_data, i);
            check("b2b_stalling", {31'd0, stalling}, 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: held beat stays put, then release swaps beats in one edge.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hCAFE_0001;
        @(negedge clk);
        in_data = 32'hCAFE_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", out_data, 32'hCAFE_0001);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_data", out_data, 32'hCAFE_0002);
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset two cycles into a stall.
        do_reset();
        cfg_en = 1'b1; cfg_mask = 8'hFF; in_valid = 1'b1; in_data = 32'hBAD0_BAD0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_stall", {31'd0, stalling}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_stalling", {31'd0, stalling}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad_ov = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) bad_ov++;
        end
        check("mid_rst_no_stale", bad_ov, 32'd0);
        send_one(1'b1, 8'hFF, 32'h0BAD_F00D, stall, lat);
        check("mid_rst_reseed_stall", stall, 32'd5);
        @(negedge clk);

`ifdef IDMA_STALL_STATS_EN
        do_reset();
        send_one(1'b1, 8'hFF, 32'hA5A5_A5A5, stall, lat);
        @(negedge clk);
        check("stat_beats", stat_beats, 32'd1);
        check("stat_stall", stat_stall, 32'd5);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("stat_beats_clr", stat_beats, 32'd0);
        check("stat_stall_clr", stat_stall, 32'd0);
`endif

        // Random traffic against the beat-indexed stall model.
        do_reset();
        cfg_en = 1'b1; cfg_mask = 8'h0F;
        m_lfsr = 32'h0000_0005;
        sent = 0; cyc = 0; stab_err = 0; long_err = 0; run = 0; cur_cnt = 0;
        new_beat = 1'b0; prev_ov = 1'b0; prev_or = 1'b0; prev_data = '0; acc = 1'b0;
        streak_o = 0; streak_i = 0; max_streak = 0;
        while ((sent < 3000 || exp_q.size() != 0) && cyc < 60000) begin
            if (prev_ov && !prev_or && !(out_valid && out_data == prev_data)) stab_err++;
            if (stalling) run++;
            if (out_valid && new_beat) begin
                check("rand_stall_len", run, cur_cnt);
                if (run > 15) long_err++;
                new_beat = 1'b0;
                run = 0;
            end
            if (acc) in_valid = 1'b0;
            if (!in_valid && sent < 3000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            hs  = out_valid && out_ready;
            acc = in_valid && in_ready;
            if (hs) begin
                if (exp_q.size() == 0) check("rand_spurious_beat", 32'd1, 32'd0);
                else check("rand_data", out_data, exp_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(in_data);
                cur_cnt  = m_lfsr[7:0] & 8'h0F;
                m_lfsr   = lfsr_step(m_lfsr);
                new_beat = 1'b1;
                run      = 0;
                sent++;
            end
            streak_o = (out_valid && !out_ready) ? streak_o + 1 : 0;
            streak_i = (in_valid && !in_ready) ? streak_i + 1 : 0;
            if (streak_o > max_streak) max_streak = streak_o;
            if (streak_i > max_streak) max_streak = streak_i;
            prev_ov   = out_valid;
            prev_or   = out_ready;
            prev_data = out_data;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_all_sent", sent, 32'd3000);
        check("rand_queue_empty", exp_q.size(), 32'd0);
        check("rand_stability", stab_err, 32'd0);
        check("rand_stall_bound", long_err, 32'd0);
        check("rand_watchdog", {31'd0, max_streak >= 64}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
